// File: rtl/secuenciador_programar.sv
// secuenciador_programar
// Walks one RTC programming pass: for each slot it drives the data-mux select,
// raises a write request with the slot's RTC address and waits for the
// write-cycle block to acknowledge, with a fixed idle gap between writes and
// a timeout that aborts the pass with a sticky error.
//
// Build option: define PROG_TIMER_EN to include the timer slots 6..8 in the
// sequence (0..9); without it the sequence is 0..5 then 9.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SETUP | select settled onto the mux, one cycle
// REQ   | arm write request and clear the timeout counter
// WAIT  | request held until wr_done or timeout
// GAP   | GAP_CYC idle cycles before the next slot
// DONE  | one-cycle done pulse
module secuenciador_programar #(
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       wr_done,
    output logic [3:0] sel_prog,
    output logic [7:0] addr_wr,
    output logic       wr_req,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       SLOT_LAST = 4'd9;

    state_t           state_q;
    logic [3:0]       slot_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_req_q;
    logic             done_q;
    logic             error_q;

    logic [3:0]       slot_d;
    logic [7:0]       addr_d;

    // Next slot in the programming order; the transfer command always closes the pass.
    always_comb begin
        slot_d = slot_q + 4'd1;
`ifdef PROG_TIMER_EN
        slot_d = slot_q + 4'd1;
`else
        if (slot_q == 4'd5) begin
            slot_d = 4'd9;
        end
`endif
    end

    // RTC address of the current slot, only presented while a write is being set up or issued.
    always_comb begin
        addr_d = 8'h00;
        if (state_q == S_SETUP || state_q == S_REQ || state_q == S_WAIT) begin
            case (slot_q)
                4'd0:    addr_d = 8'h21;
                4'd1:    addr_d = 8'h22;
                4'd2:    addr_d = 8'h23;
                4'd3:    addr_d = 8'h24;
                4'd4:    addr_d = 8'h25;
                4'd5:    addr_d = 8'h26;
                4'd6:    addr_d = 8'h41;
                4'd7:    addr_d = 8'h42;
                4'd8:    addr_d = 8'h43;
                4'd9:    addr_d = 8'hF1;
                default: addr_d = 8'h00;
            endcase
        end
    end

    // Sequencer FSM with registered request/done/error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            slot_q   <= 4'd0;
            cnt_q    <= '0;
            wr_req_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SETUP;
                        slot_q  <= 4'd0;
                        error_q <= 1'b0;
                    end
                end
                S_SETUP: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    wr_req_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over a timeout on the same cycle.
                    if (wr_done) begin
                        wr_req_q <= 1'b0;
                        cnt_q    <= '0;
                        if (slot_q == SLOT_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        wr_req_q <= 1'b0;
                        error_q  <= 1'b1;
                        slot_q   <= 4'd0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        slot_q  <= slot_d;
                        state_q <= S_SETUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    slot_q  <= 4'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sel_prog = slot_q;
    assign addr_wr  = addr_d;
    assign wr_req   = wr_req_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_secuenciador_programar.sv
// Bench for secuenciador_programar: directed passes plus randomized response
// delays, checked against a slot-list reference model.
module tb_secuenciador_programar;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       wr_done = 1'b0;
    logic [3:0] sel_prog;
    logic [7:0] addr_wr;
    logic       wr_req;
    logic       busy;
    logic       done;
    logic       error;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int done_cnt = 0;

    int dly[10];
    bit poke_start = 1'b0;
    bit spur_gap   = 1'b0;
    int seq[$];

    secuenciador_programar #(
        .GAP_CYC(4),
        .TIMEOUT_CYC(255),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .wr_done(wr_done),
        .sel_prog(sel_prog),
        .addr_wr(addr_wr),
        .wr_req(wr_req),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && done) done_cnt++;
    end

    function automatic logic [7:0] addr_of(input int s);
        if (s <= 5) return 8'(8'h21 + s);
        else if (s <= 8) return 8'(8'h41 + s - 6);
        else return 8'hF1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dly(input int d);
        for (int i = 0; i < 10; i++) dly[i] = d;
    endtask

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("error_cleared", error, 0);
        chk("setup_sel", sel_prog, 0);
        chk("setup_addr", addr_wr, 8'h21);
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (!wr_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = wr_req;
    endtask

    // stop_at: sequence index where wr_done is withheld (or reset applied when do_reset)
    task automatic run_pass(input int stop_at, input bit do_reset);
        int d0;
        int n;
        int last;
        bit ok;
        d0 = done_cnt;
        last = seq.size() - 1;
        for (int k = 0; k <= last; k++) begin
            wait_req(ok);
            chk("req_seen", ok, 1);
            if (!ok) return;
            chk("sel_prog", sel_prog, seq[k]);
            chk("addr_wr", addr_wr, addr_of(seq[k]));
            if (k == stop_at && do_reset) begin
                @(negedge clk);
                #1 reset_n = 1'b0;
                #1;
                chk("rst_wr_req", wr_req, 0);
                chk("rst_busy", busy, 0);
                chk("rst_sel", sel_prog, 0);
                chk("rst_addr", addr_wr, 0);
                @(negedge clk);
                reset_n = 1'b1;
                repeat (5) @(negedge clk);
                chk("post_rst_idle", busy, 0);
                chk("post_rst_req", wr_req, 0);
                chk("post_rst_no_done", done_cnt - d0, 0);
                return;
            end
            if (k == stop_at) begin
                n = 1;
                while (wr_req && n < 300) begin
                    @(negedge clk);
                    if (wr_req) n++;
                end
                chk("timeout_len", n, 255);
                chk("timeout_error", error, 1);
                chk("timeout_busy", busy, 0);
                chk("timeout_req", wr_req, 0);
                repeat (3) @(negedge clk);
                chk("timeout_sticky", error, 1);
                chk("timeout_no_done", done_cnt - d0, 0);
                return;
            end
            if (poke_start && k == 5 && dly[k] >= 3) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (dly[k] - 3) @(negedge clk);
            end else begin
                repeat (dly[k] - 1) @(negedge clk);
            end
            wr_done = 1'b1;
            @(negedge clk);
            wr_done = spur_gap && (k < last);
            chk("req_dropped", wr_req, 0);
            if (k == last) begin
                chk("done_pulse", done, 1);
                wr_done = 1'b0;
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("end_busy", busy, 0);
                chk("end_sel", sel_prog, 0);
                chk("end_addr", addr_wr, 0);
                @(negedge clk);
                chk("done_count", done_cnt - d0, 1);
                chk("end_error", error, 0);
            end else begin
                n = 0;
                do begin
                    @(negedge clk);
                    wr_done = 1'b0;
                    n++;
                end while (!wr_req && n < 20);
                chk("gap_len", n, 6);
            end
        end
    endtask

    initial begin
`ifdef PROG_TIMER_EN
        for (int s = 0; s <= 9; s++) seq.push_back(s);
`else
        for (int s = 0; s <= 5; s++) seq.push_back(s);
        seq.push_back(9);
`endif
        // reset values
        #2;
        chk("reset_sel", sel_prog, 0);
        chk("reset_addr", addr_wr, 0);
        chk("reset_req", wr_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // full pass, wr_done 3 cycles after each request, gap length checked
        set_dly(3);
        start_pass();
        run_pass(-1, 1'b0);

        // timeout on slot 3, then restart from slot 0
        start_pass();
        run_pass(3, 1'b0);
        start_pass();
        run_pass(-1, 1'b0);

        // start re-pulsed while busy, spurious wr_done in GAP and IDLE
        poke_start = 1'b1;
        spur_gap   = 1'b1;
        start_pass();
        run_pass(-1, 1'b0);
        poke_start = 1'b0;
        spur_gap   = 1'b0;
        @(negedge clk);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_spur_busy", busy, 0);
        chk("idle_spur_req", wr_req, 0);

        // asynchronous reset in the middle of a write
        start_pass();
        run_pass(6, 1'b1);
        start_pass();
        run_pass(-1, 1'b0);

        // wr_done on the final WAIT cycle counts as success
        set_dly(3);
        dly[3] = 255;
        start_pass();
        run_pass(-1, 1'b0);

        // randomized response delays
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) dly[i] = $urandom_range(1, 8);
            poke_start = (dly[5] >= 3);
            spur_gap   = $urandom_range(0, 1) == 1;
            start_pass();
            run_pass(-1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
